iot_byte_feeder: RTL
====================

// Module: iot_byte_feeder
// PURPOSE
//  Upstream stage of the IoT data filter (IOTDF). Accepts 128-bit sensor words
//  over a valid/ready port, buffers them in a small FIFO, and serializes each
//  word MSB-byte-first onto the 8-bit iot_in/in_en bus, honouring IOTDF busy.
//  It replaces the bench-side byte driver, so the filter receives identical
//  traffic in system use.
// PARAMETERS
//  DEPTH   4   FIFO depth in 128-bit words; power of 2, >=2
//  CNT_W   16  width of the completed-word counter; wraps modulo 2**CNT_W
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  rst       in   1      asynchronous, active-high reset
//  s_valid   in   1      producer has a word on s_data
//  s_data    in   128    sensor word; bits[127:120] are sent first
//  s_ready   out  1      FIFO not full; word accepted when s_valid&&s_ready
//  busy      in   1      IOTDF busy; sampled at clk edge
//  in_en     out  1      registered; byte valid on iot_in
//  iot_in    out  8      registered byte to IOTDF
//  idle      out  1      FIFO empty and no word in flight
//  word_cnt  out  CNT_W  count of words fully transmitted (16 bytes issued)
// BEHAVIOUR
//  Reset (async, immediate): in_en=0, iot_in=8'h00, s_ready=1, idle=1,
//   word_cnt=0, FIFO flushed, byte_idx=0. A partial word in flight is discarded.
//  FIFO: push on s_valid&&s_ready. s_ready=!full (combinational from count).
//   There is no bypass, so when full s_ready=0 even on a pop cycle.
//   Data pushed at edge N is eligible for byte 0 at edge N+1.
//  Serializer FSM: IDLE (FIFO empty) / SEND (head word present, byte_idx 0..15).
//   At each edge in SEND:
//   - busy=0: iot_in<=head[127-8*byte_idx -: 8], in_en<=1, byte_idx++.
//     On byte_idx==15: pop head, byte_idx<=0, word_cnt++. Next word's byte 0
//     follows on the very next edge with no bubble. Go to IDLE if FIFO is now
//     empty, counting the same-edge pop.
//   - busy=1: in_en<=0, iot_in<=8'h00, byte_idx held. The stall resumes with
//     the next unsent byte; no byte is skipped or duplicated.
//   In IDLE: in_en<=0, iot_in<=8'h00.
//  busy is sampled only at the edge; a busy pulse between edges has no effect.
//  Simultaneous push + pop (not full): both take effect; count unchanged.
//  idle = (FIFO count==0) && (byte_idx==0). word_cnt wraps to 0 after all-ones.
//  Pointers: log2(DEPTH) bits, wrap naturally. Count: log2(DEPTH)+1 bits.
// STRUCTURE
//  iot_pkg: IOT_WORD_W=128, IOT_BYTE_W=8, IOT_BYTES_PER_WORD=16,
//   feeder state enum {FD_IDLE, FD_SEND}.
//  Sub-module iot_word_fifo (DEPTH x 128, sync push/pop, full/empty/count, async
//   rst). Top holds the FSM, byte_idx[3:0], the output registers and word_cnt.
// TESTING
//  T1 async reset mid-cycle while in_en=1
//     -> in_en=0, iot_in=00, s_ready=1, idle=1, word_cnt=0 with no clock edge.
//  T2 push 128'h00112233_44556677_8899AABB_CCDDEEFF, busy=0
//     -> 16 consecutive edges with in_en=1, bytes 00,11,...,FF;
//        word_cnt=1 and idle=1 after the 16th byte.
//  T3 same word, busy=1 for 3 edges after byte 0x55
//     -> 3 edges with in_en=0/iot_in=00, then 0x66; 16 bytes total, none repeated.
//  T4 busy=1, offer 5 words, DEPTH=4
//     -> s_ready=0 after the 4th accept and the 5th is held.
//        Release busy -> 64 back-to-back bytes; s_ready rises after the 16th byte.
//  T5 assert rst after byte 9 of a word, then push a new word
//     -> the new word starts at its byte 0; word_cnt counts from 0; old FIFO content gone.
//  T6 system: 96 words from pattern1.dat into IOTDF with fn_sel=1
//     -> 12 valid outputs match f1.dat. Repeat with CNT_W=2 and 5 words
//        -> word_cnt goes 1,2,3,0,1.

Source files
------------

// File: rtl/iot_pkg.sv
// Shared types and constants for the IOTDF upstream byte feeder.
// Holds word/byte geometry, the serializer state encoding and a byte-select helper.
package iot_pkg;

    localparam int IOT_WORD_W         = 128;
    localparam int IOT_BYTE_W         = 8;
    localparam int IOT_BYTES_PER_WORD = 16;
    localparam int IOT_IDX_W          = 4;

    typedef enum logic [0:0] {
        FD_IDLE = 1'b0,
        FD_SEND = 1'b1
    } feeder_state_e;

    // Byte 0 is the most significant byte of the word.
    function automatic logic [IOT_BYTE_W-1:0] word_byte(
        input logic [IOT_WORD_W-1:0] word,
        input logic [IOT_IDX_W-1:0]  idx
    );
        return word[(IOT_WORD_W - 1) - (IOT_BYTE_W * int'(idx)) -: IOT_BYTE_W];
    endfunction

endpackage

// File: rtl/iot_word_fifo.sv
// Synchronous DEPTH x 128-bit word FIFO with full/empty/count flags.
// Storage is not reset; emptiness is defined purely by the occupancy count.
module iot_word_fifo
    import iot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [IOT_WORD_W-1:0]      push_data,
    input  logic                       pop,
    output logic [IOT_WORD_W-1:0]      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [IOT_WORD_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W:0]        count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full  = (count_r == (PTR_W + 1)'(DEPTH));
    assign empty = (count_r == {(PTR_W + 1){1'b0}});
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // Qualify requests so an overflowing push or underflowing pop is ignored.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Word storage write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/iot_byte_feeder.sv
// Buffers 128-bit sensor words and serializes them MSB-byte-first onto the
// IOTDF iot_in/in_en bus, stalling on busy and counting completed words.
module iot_byte_feeder
    import iot_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [IOT_WORD_W-1:0] s_data,
    output logic                  s_ready,
    input  logic                  busy,
    output logic                  in_en,
    output logic [IOT_BYTE_W-1:0] iot_in,
    output logic                  idle,
    output logic [CNT_W-1:0]      word_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    feeder_state_e          state_r;
    logic [IOT_IDX_W-1:0]   byte_idx_r;
    logic                   in_en_r;
    logic [IOT_BYTE_W-1:0]  iot_in_r;
    logic [CNT_W-1:0]       word_cnt_r;

    logic [IOT_WORD_W-1:0]  fifo_head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [CW-1:0]          fifo_count_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   last_byte_s;
    logic [CW-1:0]          count_next_s;

    iot_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (s_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Handshake, end-of-word pop and post-edge occupancy (includes a same-edge push).
    always_comb begin
        push_s       = s_valid && !fifo_full_s;
        last_byte_s  = (byte_idx_r == 4'd15);
        pop_s        = (state_r == FD_SEND) && !busy && last_byte_s;
        count_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
    end

    assign s_ready  = !fifo_full_s;
    assign idle     = fifo_empty_s && (byte_idx_r == 4'd0);
    assign in_en    = in_en_r;
    assign iot_in   = iot_in_r;
    assign word_cnt = word_cnt_r;

    // Serializer FSM: SEND is held exactly while the FIFO holds a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= FD_IDLE;
            byte_idx_r <= 4'd0;
            in_en_r    <= 1'b0;
            iot_in_r   <= 8'h00;
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                FD_IDLE: begin
                    in_en_r  <= 1'b0;
                    iot_in_r <= 8'h00;
                    if (push_s) begin
                        state_r <= FD_SEND;
                    end else begin
                        state_r <= FD_IDLE;
                    end
                end
                FD_SEND: begin
                    if (busy) begin
                        in_en_r  <= 1'b0;
                        iot_in_r <= 8'h00;
                    end else begin
                        in_en_r    <= 1'b1;
                        iot_in_r   <= word_byte(fifo_head_s, byte_idx_r);
                        byte_idx_r <= byte_idx_r + 4'd1;
                        if (last_byte_s) begin
                            word_cnt_r <= word_cnt_r + CNT_W'(1);
                            if (count_next_s == {CW{1'b0}}) begin
                                state_r <= FD_IDLE;
                            end else begin
                                state_r <= FD_SEND;
                            end
                        end else begin
                            state_r <= FD_SEND;
                        end
                    end
                end
                default: begin
                    state_r    <= FD_IDLE;
                    byte_idx_r <= 4'd0;
                    in_en_r    <= 1'b0;
                    iot_in_r   <= 8'h00;
                end
            endcase
        end
    end

endmodule
